note_player: RTL and testbench

Playback engine for the composition grid. On `start`, it reads the placed notes from the shared note RAM in slot order, holds each one for one beat, and drives the audio codec with a square-wave sample stream at the note's pitch. It sits between the note RAM, which user I/O writes, and the audio codec. It also exports the current playback slot so the VGA path can highlight the column being played.

---
 rtl/note_pkg.sv | 17 +
 rtl/note_player_if.sv | 13 +
 rtl/note_period_rom.sv | 29 ++
 rtl/note_player.sv | 145 ++++++++++++++
 tb/tb_note_player.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the composition-grid playback path.
package note_pkg;

    localparam int N_SLOTS     = 40;
    localparam int NUM_PITCHES = 36;
    localparam int SAMPLE_RATE = 48000;

    typedef logic [5:0] note_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } player_state_t;

endpackage

// File: rtl/note_player_if.sv
// Note RAM read port and codec sample port seen by the player.
interface note_player_if;
    import note_pkg::*;

    note_t       ram_addr;
    note_t       ram_rdata;
    logic        write_ready;
    logic        write;
    logic [23:0] audio_out;

    modport master (output ram_addr, write, audio_out, input ram_rdata, write_ready);
    modport slave  (input ram_addr, write, audio_out, output ram_rdata, write_ready);
endinterface

// File: rtl/note_period_rom.sv
// Note value to square-wave half-period (in 48 kHz samples); 0 marks a rest.
module note_period_rom
    import note_pkg::*;
(
    input  note_t      note_i,
    output logic [6:0] half_o
);

    // Table of round(24000 / f) for C4..B6
    always_comb begin
        half_o = 7'd0;
        case (note_i)
            6'd0:  half_o = 7'd92;  6'd1:  half_o = 7'd87;  6'd2:  half_o = 7'd82;
            6'd3:  half_o = 7'd77;  6'd4:  half_o = 7'd73;  6'd5:  half_o = 7'd69;
            6'd6:  half_o = 7'd65;  6'd7:  half_o = 7'd61;  6'd8:  half_o = 7'd58;
            6'd9:  half_o = 7'd55;  6'd10: half_o = 7'd51;  6'd11: half_o = 7'd49;
            6'd12: half_o = 7'd46;  6'd13: half_o = 7'd43;  6'd14: half_o = 7'd41;
            6'd15: half_o = 7'd39;  6'd16: half_o = 7'd36;  6'd17: half_o = 7'd34;
            6'd18: half_o = 7'd32;  6'd19: half_o = 7'd31;  6'd20: half_o = 7'd29;
            6'd21: half_o = 7'd27;  6'd22: half_o = 7'd26;  6'd23: half_o = 7'd24;
            6'd24: half_o = 7'd23;  6'd25: half_o = 7'd22;  6'd26: half_o = 7'd20;
            6'd27: half_o = 7'd19;  6'd28: half_o = 7'd18;  6'd29: half_o = 7'd17;
            6'd30: half_o = 7'd16;  6'd31: half_o = 7'd15;  6'd32: half_o = 7'd14;
            6'd33: half_o = 7'd14;  6'd34: half_o = 7'd13;  6'd35: half_o = 7'd12;
            default: half_o = 7'd0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// Playback engine: walks the note RAM slot by slot, one beat per note,
// streaming a square wave at each note's pitch to the codec.
module note_player #(
    parameter int          N_SLOTS     = 40,
    parameter int          BEAT_CYCLES = 12_500_000,
    parameter logic [23:0] AMPLITUDE   = 24'h10_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [5:0]    i_note,
    note_player_if.master bus,
    output logic [5:0]    play_pos,
    output logic          playing,
    output logic          done
);
    import note_pkg::*;

    localparam logic [23:0] BEAT_LAST = 24'(BEAT_CYCLES - 1);
    localparam logic [23:0] NEG_AMP   = ~AMPLITUDE + 24'd1;
    localparam logic [5:0]  SLOT_MAX  = 6'(N_SLOTS);

    player_state_t state_q, state_d;
    note_t         pos_q, pos_d, cur_note_q, cur_note_d;
    logic [23:0]   beat_q, beat_d, audio_q, audio_d;
    logic [6:0]    phase_q, phase_d, half_s;
    logic          pol_q, pol_d, done_q, done_d, playing_q;
    logic          wr_s, more_s;
    logic [5:0]    n_eff_s;

    note_period_rom u_rom (.note_i(cur_note_q), .half_o(half_s));

    assign wr_s    = bus.write_ready & ~reset;
    assign n_eff_s = (i_note > SLOT_MAX) ? SLOT_MAX : i_note;
    assign more_s  = ({1'b0, pos_q} + 7'd1) < {1'b0, n_eff_s};

    assign bus.write     = wr_s;
    assign bus.ram_addr  = pos_q;
    assign bus.audio_out = audio_q;
    assign play_pos      = pos_q;
    assign playing       = playing_q;
    assign done          = done_q;

    // Sequencer next state, beat/phase counters and next audio sample
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        cur_note_d = cur_note_q;
        beat_d     = beat_q;
        phase_d    = phase_q;
        pol_d      = pol_q;
        audio_d    = 24'd0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (i_note != 6'd0)) begin
                    state_d = S_FETCH;
                    pos_d   = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                cur_note_d = bus.ram_rdata;
                beat_d     = 24'd0;
                phase_d    = 7'd0;
                pol_d      = 1'b1;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                beat_d  = beat_q + 24'd1;
                audio_d = audio_q;
                if ((half_s != 7'd0) && wr_s) begin
                    audio_d = pol_q ? AMPLITUDE : NEG_AMP;
                    if (phase_q == half_s - 7'd1) begin
                        phase_d = 7'd0;
                        pol_d   = ~pol_q;
                    end else begin
                        phase_d = phase_q + 7'd1;
                    end
                end else begin
                    phase_d = phase_q;
                end
                // Beat boundary: audio drops to silence during the next fetch
                if (beat_q == BEAT_LAST) begin
                    audio_d = 24'd0;
                    if (more_s) begin
                        pos_d   = pos_q + 6'd1;
                        state_d = S_FETCH;
                    end else if (loop) begin
                        pos_d   = 6'd0;
                        state_d = S_FETCH;
                    end else begin
                        pos_d   = 6'd0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
                pos_d   = 6'd0;
            end
        endcase
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pos_d   = 6'd0;
            done_d  = 1'b0;
            audio_d = 24'd0;
        end else begin
            done_d = done_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pos_q      <= 6'd0;
            cur_note_q <= 6'd0;
            beat_q     <= 24'd0;
            phase_q    <= 7'd0;
            pol_q      <= 1'b1;
            audio_q    <= 24'd0;
            done_q     <= 1'b0;
            playing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            cur_note_q <= cur_note_d;
            beat_q     <= beat_d;
            phase_q    <= phase_d;
            pol_q      <= pol_d;
            audio_q    <= audio_d;
            done_q     <= done_d;
            playing_q  <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player against a note-timeline model.
module tb_note_player;

    localparam int          B   = 200;
    localparam logic [23:0] AMP = 24'h10_0000;

    typedef struct {
        logic        playing;
        logic [5:0]  pos;
        logic        done;
        logic [23:0] audio;
        logic        chk_addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1, start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0, wr_i = 1'b0;
    logic [5:0] n_i = 6'd0;
    logic [5:0] play_pos;
    logic       playing, done;
    logic [5:0] ram_mem [64];

    int checks = 0, errors = 0, done_seen = 0, wr_mode = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // model state
    int m_act = 0, m_pos = 0, m_t = 0, m_w = 0, m_half = 0;
    logic [23:0] m_aud = 24'd0;

    note_player_if bus ();

    note_player #(.N_SLOTS(40), .BEAT_CYCLES(B), .AMPLITUDE(AMP)) dut (
        .clk(clk), .reset(rst_i), .start(start_i), .stop(stop_i), .loop(loop_i),
        .i_note(n_i), .bus(bus), .play_pos(play_pos), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;
    assign bus.write_ready = wr_i;
    always @(posedge clk) bus.ram_rdata <= ram_mem[bus.ram_addr];

    function automatic int half_of(int v);
        if (v > 35) return 0;
        return int'($floor(24000.0 / (261.63 * $pow(2.0, real'(v) / 12.0)) + 0.5));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, ex);
        end
    endtask

    // One clock edge: advance the reference timeline and queue the expected outputs
    task automatic tick();
        exp_t e;
        int   n_eff;
        logic d;
        @(posedge clk);
        d = 1'b0;
        n_eff = (n_i > 6'd40) ? 40 : int'(n_i);
        if (rst_i) begin
            m_act = 0; m_pos = 0; m_aud = 24'd0;
        end else if (m_act == 0) begin
            m_aud = 24'd0;
            if (start_i && n_i != 6'd0) begin m_act = 1; m_pos = 0; m_t = 0; end
        end else if (stop_i) begin
            m_act = 0; m_pos = 0; m_aud = 24'd0;
        end else if (m_t == 0) begin
            m_t = 1;
        end else if (m_t == 1) begin
            m_t = 2; m_w = 0; m_aud = 24'd0;
            m_half = half_of(int'(ram_mem[m_pos]));
        end else if (m_t == B + 1) begin
            m_aud = 24'd0;
            if (m_pos + 1 < n_eff) begin m_pos++; m_t = 0; end
            else if (loop_i) begin m_pos = 0; m_t = 0; end
            else begin m_act = 0; m_pos = 0; d = 1'b1; end
        end else begin
            m_t++;
            if (m_half != 0 && wr_i) begin
                m_aud = (((m_w / m_half) % 2) == 0) ? AMP : (~AMP + 24'd1);
                m_w++;
            end
        end
        e.playing  = (m_act != 0);
        e.pos      = 6'(m_pos);
        e.done     = d;
        e.audio    = m_aud;
        e.chk_addr = (m_act == 0) || (m_t == 0);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            case (wr_mode)
                0: wr_i = 1'b1;
                1: wr_i = ($urandom_range(0, 3) != 0);
                default: wr_i = ~wr_i;
            endcase
            tick();
            #1;
            start_i = 1'b0;
            stop_i  = 1'b0;
        end
    endtask

    task automatic run_idle(input int cap);
        int c = 0;
        while (m_act != 0 && c < cap) begin cyc(1); c++; end
        if (m_act != 0) begin
            errors++;
            $display("FAIL timeout: playback still active after %0d cycles", cap);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        chk("write", 32'(bus.write), 32'(wr_i & ~rst_i));
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("playing", 32'(playing), 32'(mon_e.playing));
            chk("play_pos", 32'(play_pos), 32'(mon_e.pos));
            chk("done", 32'(done), 32'(mon_e.done));
            chk("audio_out", 32'(bus.audio_out), 32'(mon_e.audio));
            if (mon_e.chk_addr) chk("ram_addr", 32'(bus.ram_addr), 32'(mon_e.pos));
            if (done) done_seen++;
        end
    end

    initial begin
        int base;
        for (int i = 0; i < 64; i++) ram_mem[i] = 6'd0;
        rst_i = 1'b1; cyc(3); rst_i = 1'b0; cyc(2);

        // basic playback: A4, C4, rest
        ram_mem[0] = 6'd9; ram_mem[1] = 6'd0; ram_mem[2] = 6'd40;
        n_i = 6'd3; base = done_seen;
        start_i = 1'b1; cyc(1); run_idle(4 * (B + 2)); cyc(3);
        chk("basic_done_count", 32'(done_seen - base), 32'd1);

        // looping single note, then release loop
        n_i = 6'd1; loop_i = 1'b1; base = done_seen;
        start_i = 1'b1; cyc(3 * (B + 2) + 5);
        loop_i = 1'b0; run_idle(2 * (B + 2)); cyc(3);
        chk("loop_done_count", 32'(done_seen - base), 32'd1);

        // stop on the final beat cycle
        ram_mem[0] = 6'd5; ram_mem[1] = 6'd20; n_i = 6'd2; base = done_seen;
        start_i = 1'b1; cyc(1);
        for (int c = 0; c < 3 * (B + 2) && !(m_t == B + 1 && m_pos == 1); c++) cyc(1);
        stop_i = 1'b1; cyc(3);
        chk("stop_no_done", 32'(done_seen - base), 32'd0);

        // empty grid
        n_i = 6'd0; start_i = 1'b1; cyc(5);

        // backpressure on B6
        ram_mem[0] = 6'd35; n_i = 6'd1; wr_mode = 2;
        start_i = 1'b1; cyc(1); run_idle(2 * (B + 2)); cyc(2);

        // reset mid-note, then clean restart
        ram_mem[0] = 6'd3; ram_mem[1] = 6'd7; n_i = 6'd2; wr_mode = 1;
        start_i = 1'b1; cyc(1); cyc(2 + 5);
        rst_i = 1'b1; cyc(1); rst_i = 1'b0; cyc(2);
        start_i = 1'b1; cyc(1); run_idle(3 * (B + 2)); cyc(2);

        // randomized sequences with live i_note changes, stray start/stop
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < 40; s++) ram_mem[s] = 6'($urandom_range(0, 63));
            n_i = (it == 0) ? 6'd45 : 6'($urandom_range(1, 5));
            start_i = 1'b1; cyc(1);
            for (int c = 0; c < 45 * (B + 2) && m_act != 0; c++) begin
                if ($urandom_range(0, 1999) == 0) stop_i = 1'b1;
                if ($urandom_range(0, 499) == 0) start_i = 1'b1;
                if ($urandom_range(0, 399) == 0) n_i = 6'($urandom_range(0, int'(n_i)));
                cyc(1);
            end
            run_idle(B + 4);
            cyc(3);
        end

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
